// File: rtl/mesh_slave_mem.sv
// rtl/mesh_slave_mem.sv - word-addressed memory target behind a manycore endpoint
//
// Services remote stores and loads arriving on the endpoint request interface.
// A clear sequencer zeroes the array after reset and on request. Load data
// returns one cycle after acceptance.
//
// Ports:
//   clk_i, reset_n_i           clock, asynchronous active-low reset
//   in_v_i / in_yumi_o         request valid / accepted this cycle
//   in_data_i, in_mask_i       store payload and byte enables
//   in_addr_i, in_we_i         word address, 1 = store / 0 = load
//   returning_v_o/_data_o      load data back to the endpoint
//   clear_i, busy_o            start a clear / clear in progress
//   err_o                      sticky out-of-range flag
//   store_count_o, load_count_o saturating accepted-request counters
module mesh_slave_mem #(
   parameter int data_width_p  = 32,
   parameter int addr_width_p  = 32,
   parameter int els_p         = 32,
   parameter int count_width_p = 16
) (
   input  logic                      clk_i,
   input  logic                      reset_n_i,
   input  logic                      in_v_i,
   output logic                      in_yumi_o,
   input  logic [data_width_p-1:0]   in_data_i,
   input  logic [data_width_p/8-1:0] in_mask_i,
   input  logic [addr_width_p-1:0]   in_addr_i,
   input  logic                      in_we_i,
   output logic                      returning_v_o,
   output logic [data_width_p-1:0]   returning_data_o,
   input  logic                      clear_i,
   output logic                      busy_o,
   output logic                      err_o,
   output logic [count_width_p-1:0]  store_count_o,
   output logic [count_width_p-1:0]  load_count_o
);

   localparam int idx_w_lp  = (els_p > 1) ? $clog2(els_p) : 1;
   localparam int mask_w_lp = data_width_p / 8;

   localparam logic [data_width_p-1:0] dead_lp     = data_width_p'(64'hDEAD_BEEF);
   localparam logic [addr_width_p-1:0] els_addr_lp = addr_width_p'(els_p);
   localparam logic [idx_w_lp-1:0]     last_idx_lp = idx_w_lp'(els_p - 1);

   typedef enum logic {eClear, eServe} state_e;

   state_e                  state_r;
   logic [idx_w_lp-1:0]     idx_r;
   logic [data_width_p-1:0] mem_r [els_p];

   logic                    in_range;
   logic [idx_w_lp-1:0]     addr_idx;
   logic                    accept;

   // Range check uses the full address so high garbage bits never alias.
   assign in_range  = (in_addr_i < els_addr_lp);
   assign addr_idx  = in_addr_i[idx_w_lp-1:0];
   assign accept    = (state_r == eServe) && in_v_i;
   assign in_yumi_o = accept;
   assign busy_o    = (state_r == eClear);

   always_ff @(posedge clk_i or negedge reset_n_i) begin
      if (!reset_n_i) begin
         state_r          <= eClear;
         idx_r            <= '0;
         returning_v_o    <= 1'b0;
         returning_data_o <= '0;
         err_o            <= 1'b0;
         store_count_o    <= '0;
         load_count_o     <= '0;
      end else begin
         case (state_r)
            eClear: begin
               // A fresh clear request restarts the sweep from word 0.
               if (clear_i) begin
                  idx_r <= '0;
               end else if (idx_r == last_idx_lp) begin
                  state_r <= eServe;
                  idx_r   <= '0;
               end else begin
                  idx_r <= idx_r + idx_w_lp'(1);
               end
            end
            eServe: begin
               // The request in the same cycle as clear_i is still serviced.
               if (clear_i) begin
                  state_r <= eClear;
                  idx_r   <= '0;
               end
            end
            default: begin
               state_r <= eClear;
               idx_r   <= '0;
            end
         endcase

         returning_v_o <= accept && !in_we_i;

         if (accept && !in_we_i) begin
            returning_data_o <= in_range ? mem_r[addr_idx] : dead_lp;
         end

         if (accept && !in_range) begin
            err_o <= 1'b1;
         end

         if (accept && in_we_i && (store_count_o != '1)) begin
            store_count_o <= store_count_o + count_width_p'(1);
         end

         if (accept && !in_we_i && (load_count_o != '1)) begin
            load_count_o <= load_count_o + count_width_p'(1);
         end
      end
   end

   // Storage is deliberately not reset; contents become defined once the
   // clear sweep has visited every word.
   always_ff @(posedge clk_i) begin
      if (state_r == eClear) begin
         mem_r[idx_r] <= '0;
      end else if (accept && in_we_i && in_range) begin
         for (int b = 0; b < mask_w_lp; b++) begin
            if (in_mask_i[b]) begin
               mem_r[addr_idx][8*b +: 8] <= in_data_i[8*b +: 8];
            end
         end
      end
   end

endmodule

// File: doc/mesh_slave_mem.md
# mesh_slave_mem

Local memory target on the far side of a `bsg_manycore_endpoint_standard` instance. It consumes the endpoint's incoming request interface and services remote stores and remote loads from a word-addressed flop array. Load data goes back through the endpoint's returning-data port exactly one cycle after the request is accepted. It is the destination tile that a mesh master's write-then-read sequence exercises, and it adds a hardware clear sequencer, an error flag and traffic counters for bench checking.

## Interface
- data_width_p, 32, word width; must be a multiple of 8
- addr_width_p, 32, width of in_addr_i (word address)
- els_p, 32, memory depth in words; ≥2; need not be a power of two
- count_width_p, 16, width of the store/load counters
- clk_i  in  1  clock
- reset_n_i  in  1  reset; asynchronous, active-low
- in_v_i  in  1  endpoint request valid
- in_yumi_o  out  1  request accepted this cycle
- in_data_i  in  data_width_p  store payload
- in_mask_i  in  data_width_p/8  byte enables for stores
- in_addr_i  in  addr_width_p  word address
- in_we_i  in  1  1 = remote store, 0 = remote load
- returning_v_o  out  1  load data valid, to endpoint returning_v_i
- returning_data_o  out  data_width_p  load data, to endpoint returning_data_i
- clear_i  in  1  pulse: zero the whole memory
- busy_o  out  1  clear in progress; no requests accepted
- err_o  out  1  sticky out-of-range flag
- store_count_o  out  count_width_p  accepted stores, saturating
- load_count_o  out  count_width_p  accepted loads, saturating

## Operation
- FSM has two states, eClear and eServe. Reset enters eClear with clear index 0.
- eClear:
  - Writes 0 to mem[idx] each cycle and increments idx.
  - When idx == els_p-1, the next state is eServe.
  - busy_o = 1 and in_yumi_o = 0.
  - If clear_i is asserted during eClear, idx restarts at 0.
- eServe:
  - in_yumi_o = in_v_i (combinational). No request is ever held off in this state.
  - If clear_i is asserted, the next state is eClear with idx = 0. A request presented in the same cycle is still accepted and fully serviced.
- Address decode:
  - The request is in range when in_addr_i < els_p, compared over the full addr_width_p bits.
  - An out-of-range store is dropped.
  - An out-of-range load returns 32'hDEAD_BEEF, truncated or zero-extended to data_width_p.
  - Either case sets err_o. err_o clears only on reset.
- Store: for each byte b with in_mask_i[b] = 1, mem[addr][8b+7:8b] <= in_data_i[8b+7:8b]. Bytes with mask 0 are unchanged. The write takes effect at the accepting edge.
- Load: mem[addr] is read in the accepting cycle and registered into returning_data_o.
- Counters:
  - An accepted store increments store_count_o; an accepted load increments load_count_o.
  - Out-of-range requests are counted too.
  - Both counters saturate at all-ones and are not cleared by clear_i.
- Memory contents are not reset by reset_n_i. They are defined only after the first clear completes.

## Timing
- Reset values (reset_n_i low, asynchronous):
  - in_yumi_o = 0 and returning_v_o = 0.
  - returning_data_o = 0, err_o = 0, both counts = 0.
  - busy_o = 1, state = eClear, idx = 0.
- After reset_n_i deasserts, busy_o stays 1 for exactly els_p cycles. in_yumi_o may first rise on cycle els_p+1.
- Load latency:
  - A load accepted at edge t asserts returning_v_o for exactly one cycle, t+1, with data.
  - returning_v_o is 0 following store accepts and idle cycles.
  - returning_data_o holds its last value when returning_v_o is 0.
- Back-to-back:
  - Requests may be accepted every cycle.
  - A load accepted the cycle after a store to the same address returns the new data.
- Loads accepted in the cycle clear_i is raised return pre-clear data.
- Asserting reset_n_i mid-operation drops any pending return immediately (returning_v_o = 0) and restarts the clear.

## Test plan
- **Reset and clear timing:** release reset with in_v_i = 1 -> busy_o = 1 for 32 cycles; first in_yumi_o on cycle 33; all 32 words then read back 0.
- **Master sequence:** store data k to addr k for k = 0..31 with mask 4'hF, then load addr 0..31 -> returning_v_o one cycle after each load accept with data k in order; store_count_o = 32, load_count_o = 32, err_o = 0.
- **Masked store and forwarding:** store 32'hAABBCCDD to addr 5 with mask 4'hF, then store 32'h11223344 with mask 4'b0101 in the next cycle, then load addr 5 in the cycle after -> returns 32'hAA22CC44.
- **Out of range:** store to addr 32 -> dropped and err_o = 1 from the next cycle; load addr 32'h1000_0000 -> returns 32'hDEADBEEF; memory is unchanged; store_count_o and load_count_o each increment.
- **Clear mid-traffic:** load addr 3 (holding 3) in the same cycle clear_i is pulsed -> returns 3 next cycle; busy_o = 1 for 32 cycles; a subsequent load of addr 3 returns 0; a second clear_i pulse during the clear extends busy_o to 32 cycles after that pulse.
- **Reset mid-load and saturation:** drop reset_n_i in the cycle after a load accept -> returning_v_o falls to 0 asynchronously. Separately, with count_width_p = 4, issue 20 loads -> load_count_o stays at 4'hF.
